// File: rtl/rob_mbank.sv
// Multi-bank reorder buffer: per-bank out-of-order completion, single in-order return channel.
// Optional macro ROB_MBANK_FILL_BYPASS_EN lets a fill to the next-due entry go straight to the output.
module rob_mbank #(
  parameter int  BANK_NUM  = 4,
  parameter int  ROB_DEPTH = 8,
  parameter int  DATA_W    = 128,
  localparam int BW        = $clog2(BANK_NUM),
  localparam int IW        = $clog2(ROB_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                u_kob_rob_req,
  input  logic [BW-1:0]       u_kob_rob_bank_id,
  output logic                u_kob_rob_ack,
  output logic [IW-1:0]       u_kob_rob_id,
  input  logic                d_rc_valid,
  input  logic [BW-1:0]       d_rc_bank_id,
  input  logic [IW-1:0]       d_rc_rob_id,
  input  logic [DATA_W-1:0]   d_rc_data,
  output logic                u_ch_valid,
  input  logic                u_ch_ready,
  output logic [DATA_W-1:0]   u_ch_data,
  output logic [BW-1:0]       u_ch_bank_id,
  output logic [BANK_NUM-1:0] d_crdt_rtn,
  output logic                d_rc_err
);

  localparam int ORD_DEPTH = BANK_NUM * ROB_DEPTH;
  localparam int OW        = $clog2(ORD_DEPTH);

`ifdef ROB_MBANK_FILL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0]    data_mem [BANK_NUM][ROB_DEPTH];
  logic [ROB_DEPTH-1:0] alloc_q  [BANK_NUM];
  logic [ROB_DEPTH-1:0] done_q   [BANK_NUM];
  logic [IW:0]          tail_q   [BANK_NUM];
  logic [IW:0]          head_q   [BANK_NUM];
  logic [IW:0]          cnt_q    [BANK_NUM];
  logic [BW-1:0]        ord_mem  [ORD_DEPTH];
  logic [OW-1:0]        ord_wr_q;
  logic [OW-1:0]        ord_rd_q;

  logic              alloc_go;
  logic [BW-1:0]     hd_bank;
  logic [IW-1:0]     hd_idx;
  logic              out_free;
  logic              fill_ok;
  logic              byp;
  logic              pop;
  logic [DATA_W-1:0] pop_data;

  // NOTE: state updates use alloc_go, which omits rst_n; rst_n only gates the visible ack
  // so that the reset net never feeds synchronous data paths.
  assign alloc_go      = u_kob_rob_req & ~cnt_q[u_kob_rob_bank_id][IW];
  assign u_kob_rob_ack = alloc_go & rst_n;
  assign u_kob_rob_id  = tail_q[u_kob_rob_bank_id][IW-1:0];

  // With the order FIFO empty its read slot names a bank whose head entry is unallocated,
  // so neither the done nor the bypass path can fire; no separate empty flag is needed.
  assign hd_bank  = ord_mem[ord_rd_q];
  assign hd_idx   = head_q[hd_bank][IW-1:0];
  assign out_free = ~u_ch_valid | u_ch_ready;
  assign fill_ok  = d_rc_valid & alloc_q[d_rc_bank_id][d_rc_rob_id] & ~done_q[d_rc_bank_id][d_rc_rob_id];
  assign byp      = BYPASS & fill_ok & (d_rc_bank_id == hd_bank) & (d_rc_rob_id == hd_idx) & out_free;
  assign pop      = (done_q[hd_bank][hd_idx] & out_free) | byp;
  assign pop_data = byp ? d_rc_data : data_mem[hd_bank][hd_idx];

  // NOTE: the data array carries no reset; validity lives entirely in the alloc/done bits.
  always_ff @(posedge clk) begin
    if (fill_ok && !byp) data_mem[d_rc_bank_id][d_rc_rob_id] <= d_rc_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        alloc_q[b] <= '0;
        done_q[b]  <= '0;
        tail_q[b]  <= '0;
        head_q[b]  <= '0;
        cnt_q[b]   <= '0;
      end
      for (int i = 0; i < ORD_DEPTH; i++) ord_mem[i] <= '0;
      ord_wr_q <= '0;
      ord_rd_q <= '0;
    end else begin
      if (alloc_go) begin
        alloc_q[u_kob_rob_bank_id][tail_q[u_kob_rob_bank_id][IW-1:0]] <= 1'b1;
        done_q[u_kob_rob_bank_id][tail_q[u_kob_rob_bank_id][IW-1:0]]  <= 1'b0;
        tail_q[u_kob_rob_bank_id] <= tail_q[u_kob_rob_bank_id] + 1'b1;
        ord_mem[ord_wr_q] <= u_kob_rob_bank_id;
        ord_wr_q <= (ord_wr_q == OW'(ORD_DEPTH - 1)) ? '0 : ord_wr_q + 1'b1;
      end
      if (fill_ok && !byp) done_q[d_rc_bank_id][d_rc_rob_id] <= 1'b1;
      if (pop) begin
        alloc_q[hd_bank][hd_idx] <= 1'b0;
        done_q[hd_bank][hd_idx]  <= 1'b0;
        head_q[hd_bank] <= head_q[hd_bank] + 1'b1;
        ord_rd_q <= (ord_rd_q == OW'(ORD_DEPTH - 1)) ? '0 : ord_rd_q + 1'b1;
      end
      for (int b = 0; b < BANK_NUM; b++) begin
        cnt_q[b] <= cnt_q[b]
                  + {{IW{1'b0}}, alloc_go && (u_kob_rob_bank_id == BW'(b))}
                  - {{IW{1'b0}}, pop && (hd_bank == BW'(b))};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_ch_valid   <= 1'b0;
      u_ch_data    <= '0;
      u_ch_bank_id <= '0;
      d_crdt_rtn   <= '0;
      d_rc_err     <= 1'b0;
    end else begin
      if (pop) begin
        u_ch_valid   <= 1'b1;
        u_ch_data    <= pop_data;
        u_ch_bank_id <= hd_bank;
      end else if (u_ch_ready) begin
        u_ch_valid <= 1'b0;
      end
      d_crdt_rtn <= '0;
      if (pop) d_crdt_rtn[hd_bank] <= 1'b1;
      if (d_rc_valid && !fill_ok) d_rc_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rob_mbank.sv
// Scoreboard bench for rob_mbank: directed alloc/fill stimulus, monitor checks returns in order.
module tb_rob_mbank;

  localparam int BN = 4;
  localparam int RD = 8;
  localparam int DW = 128;
`ifdef ROB_MBANK_FILL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int EXP_LAT = BYP ? 1 : 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          u_kob_rob_req = 1'b0;
  logic [1:0]    u_kob_rob_bank_id = '0;
  logic          u_kob_rob_ack;
  logic [2:0]    u_kob_rob_id;
  logic          d_rc_valid = 1'b0;
  logic [1:0]    d_rc_bank_id = '0;
  logic [2:0]    d_rc_rob_id = '0;
  logic [DW-1:0] d_rc_data = '0;
  logic          u_ch_valid;
  logic          u_ch_ready = 1'b1;
  logic [DW-1:0] u_ch_data;
  logic [1:0]    u_ch_bank_id;
  logic [BN-1:0] d_crdt_rtn;
  logic          d_rc_err;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    bank;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   xfers = 0;
  int   crdt_cnt [BN];
  int   lat;
  int   x0;

  rob_mbank #(.BANK_NUM(BN), .ROB_DEPTH(RD), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .u_kob_rob_req     (u_kob_rob_req),
    .u_kob_rob_bank_id (u_kob_rob_bank_id),
    .u_kob_rob_ack     (u_kob_rob_ack),
    .u_kob_rob_id      (u_kob_rob_id),
    .d_rc_valid        (d_rc_valid),
    .d_rc_bank_id      (d_rc_bank_id),
    .d_rc_rob_id       (d_rc_rob_id),
    .d_rc_data         (d_rc_data),
    .u_ch_valid        (u_ch_valid),
    .u_ch_ready        (u_ch_ready),
    .u_ch_data         (u_ch_data),
    .u_ch_bank_id      (u_ch_bank_id),
    .d_crdt_rtn        (d_crdt_rtn),
    .d_rc_err          (d_rc_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input int b, input int id);
    u_kob_rob_req = 1'b1;
    u_kob_rob_bank_id = 2'(b);
    #1;
    check("alloc_ack", DW'(u_kob_rob_ack), DW'(1));
    check("alloc_id", DW'(u_kob_rob_id), DW'(id));
    cyc();
    u_kob_rob_req = 1'b0;
  endtask

  task automatic push(input int b, input logic [DW-1:0] d);
    exp_q.push_back('{data: d, bank: 2'(b)});
  endtask

  task automatic fill(input int b, input int id, input logic [DW-1:0] d);
    d_rc_valid = 1'b1;
    d_rc_bank_id = 2'(b);
    d_rc_rob_id = 3'(id);
    d_rc_data = d;
    cyc();
    d_rc_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int left);
    for (int i = 0; i < 40 && exp_q.size() != left; i++) cyc();
    check(name, DW'(exp_q.size()), DW'(left));
  endtask

  always @(negedge clk) begin
    if (rst_n && u_ch_valid && u_ch_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ret_unexpected: got data %0h bank %0d, expected no return", u_ch_data, u_ch_bank_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ret_data", u_ch_data, e.data);
        check("ret_bank", DW'(u_ch_bank_id), DW'(e.bank));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) for (int b = 0; b < BN; b++) if (d_crdt_rtn[b]) crdt_cnt[b]++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state, with a request pending during reset
    u_kob_rob_req = 1'b1;
    #2;
    check("rst_ack", DW'(u_kob_rob_ack), DW'(0));
    check("rst_valid", DW'(u_ch_valid), DW'(0));
    check("rst_data", u_ch_data, DW'(0));
    check("rst_crdt", DW'(d_crdt_rtn), DW'(0));
    check("rst_err", DW'(d_rc_err), DW'(0));
    u_kob_rob_req = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Ordering across banks, reverse-order fills
    alloc(0, 0); push(0, DW'(32'hC));
    alloc(2, 0); push(2, DW'(32'hB));
    alloc(0, 1); push(0, DW'(32'hA));
    fill(0, 1, DW'(32'hA));
    fill(2, 0, DW'(32'hB));
    fill(0, 0, DW'(32'hC));
    wait_drain("order_drain", 0);
    cyc();
    check("order_crdt0", DW'(crdt_cnt[0]), DW'(2));
    check("order_crdt2", DW'(crdt_cnt[2]), DW'(1));

    // Full bank, then refill after one pop with wrapped id
    for (int k = 0; k < RD; k++) begin
      alloc(1, k);
      push(1, DW'(32'h100 + k));
    end
    u_kob_rob_req = 1'b1;
    u_kob_rob_bank_id = 2'd1;
    d_rc_valid = 1'b1;
    d_rc_bank_id = 2'd1;
    d_rc_rob_id = 3'd0;
    d_rc_data = DW'(32'h100);
    #1;
    check("full_refuse", DW'(u_kob_rob_ack), DW'(0));
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      d_rc_valid = 1'b0;
      #1;
      if (u_kob_rob_ack) begin
        lat = i;
        break;
      end
    end
    check("refill_lat", DW'(lat), DW'(EXP_LAT));
    check("wrap_id", DW'(u_kob_rob_id), DW'(0));
    push(1, DW'(32'h108));
    cyc();
    u_kob_rob_req = 1'b0;
    wait_drain("full_first_pop", 8);
    cyc();

    // Backpressure with three completions waiting
    u_ch_ready = 1'b0;
    fill(1, 1, DW'(32'h101));
    fill(1, 2, DW'(32'h102));
    fill(1, 3, DW'(32'h103));
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("bp_valid", DW'(u_ch_valid), DW'(1));
      check("bp_data", u_ch_data, DW'(32'h101));
      check("bp_bank", DW'(u_ch_bank_id), DW'(1));
    end
    check("bp_crdt1", DW'(crdt_cnt[1]), DW'(2));
    x0 = xfers;
    u_ch_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    check("bp_rate", DW'(xfers - x0), DW'(3));
    fill(1, 7, DW'(32'h107));
    fill(1, 6, DW'(32'h106));
    fill(1, 5, DW'(32'h105));
    fill(1, 4, DW'(32'h104));
    fill(1, 0, DW'(32'h108));
    wait_drain("bp_drain", 0);
    cyc();
    check("bp_crdt1_total", DW'(crdt_cnt[1]), DW'(9));

    // Protocol errors: unallocated fill, then a double fill
    check("err_clear", DW'(d_rc_err), DW'(0));
    fill(3, 0, DW'(32'hBAD));
    check("err_unalloc", DW'(d_rc_err), DW'(1));
    u_ch_ready = 1'b0;
    alloc(3, 0); push(3, DW'(32'hD0));
    alloc(3, 1); push(3, DW'(32'hD1));
    fill(3, 0, DW'(32'hD0));
    fill(3, 1, DW'(32'hD1));
    fill(3, 1, DW'(32'hBAD));
    cyc();
    cyc();
    check("err_sticky", DW'(d_rc_err), DW'(1));
    check("err_hold_data", u_ch_data, DW'(32'hD0));
    u_ch_ready = 1'b1;
    wait_drain("err_drain", 0);
    check("err_sticky_end", DW'(d_rc_err), DW'(1));

    // Fill-to-return latency
    alloc(2, 1); push(2, DW'(32'hE1));
    d_rc_valid = 1'b1;
    d_rc_bank_id = 2'd2;
    d_rc_rob_id = 3'd1;
    d_rc_data = DW'(32'hE1);
    cyc();
    d_rc_valid = 1'b0;
    check("lat_valid_t1", DW'(u_ch_valid), DW'(BYP));
    check("lat_crdt_t1", DW'(d_crdt_rtn[2]), DW'(BYP));
    cyc();
    check("lat_valid_t2", DW'(u_ch_valid), DW'(!BYP));
    check("lat_crdt_t2", DW'(d_crdt_rtn[2]), DW'(!BYP));
    wait_drain("lat_drain", 0);

    // Reset with entries outstanding
    u_ch_ready = 1'b0;
    alloc(0, 2);
    alloc(0, 3);
    alloc(0, 4);
    alloc(3, 2);
    alloc(3, 3);
    alloc(3, 4);
    fill(0, 2, DW'(32'h55));
    cyc();
    check("pre_rst_valid", DW'(u_ch_valid), DW'(1));
    cyc();
    u_kob_rob_req = 1'b1;
    u_kob_rob_bank_id = 2'd0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", DW'(u_ch_valid), DW'(0));
    check("mid_rst_data", u_ch_data, DW'(0));
    check("mid_rst_bank", DW'(u_ch_bank_id), DW'(0));
    check("mid_rst_crdt", DW'(d_crdt_rtn), DW'(0));
    check("mid_rst_err", DW'(d_rc_err), DW'(0));
    check("mid_rst_ack", DW'(u_kob_rob_ack), DW'(0));
    u_kob_rob_req = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    u_ch_ready = 1'b1;
    alloc(0, 0); push(0, DW'(32'hF0));
    alloc(3, 0); push(3, DW'(32'hF3));
    fill(3, 0, DW'(32'hF3));
    fill(0, 0, DW'(32'hF0));
    wait_drain("post_rst_drain", 0);
    cyc();
    cyc();
    check("final_crdt0", DW'(crdt_cnt[0]), DW'(4));
    check("final_crdt1", DW'(crdt_cnt[1]), DW'(9));
    check("final_crdt2", DW'(crdt_cnt[2]), DW'(2));
    check("final_crdt3", DW'(crdt_cnt[3]), DW'(3));
    check("final_err", DW'(d_rc_err), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_mbank.md
# rob_mbank

Multi-bank reorder buffer for the xbar return path. Parametrised in bank count, per-bank depth and data width. It allocates a per-bank ROB entry on each KOB request and accepts out-of-order read completions from the banks. It returns data on a single upstream channel in global allocation order, across all banks, and pulses a per-bank credit to the issue stage whenever an entry is freed.

## Interface
Parameters:
- BANK_NUM, 4, number of banks; must be ≥2.
- ROB_DEPTH, 8, entries per bank; must be a power of two, ≥2.
- DATA_W, 128, completion data width.
- Derived: BW = $clog2(BANK_NUM), IW = $clog2(ROB_DEPTH), ORD_DEPTH = BANK_NUM*ROB_DEPTH.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- u_kob_rob_req  in  1  allocation request.
- u_kob_rob_bank_id  in  BW  target bank of the request.
- u_kob_rob_ack  out  1  allocation granted this cycle (combinational).
- u_kob_rob_id  out  IW  entry index allocated; valid when ack is high.
- d_rc_valid  in  1  completion valid.
- d_rc_bank_id  in  BW  completion bank.
- d_rc_rob_id  in  IW  completion entry index.
- d_rc_data  in  DATA_W  completion data.
- u_ch_valid  out  1  return data valid (registered).
- u_ch_ready  in  1  upstream accept.
- u_ch_data  out  DATA_W  return data.
- u_ch_bank_id  out  BW  bank the returned data came from.
- d_crdt_rtn  out  BANK_NUM  one-cycle credit pulse per bank.
- d_rc_err  out  1  sticky protocol-error flag.

## Operation
- Per bank state: data array [ROB_DEPTH], alloc bit and done bit per entry, tail pointer, head pointer and count, each IW+1 bits wide.
- Global order FIFO of ORD_DEPTH×BW holds the bank id of each allocation. It cannot overflow, because the per-bank counts bound it.
- Allocation:
  - ack = req & (count[bank_id] < ROB_DEPTH) & rst_n.
  - id = tail[bank_id].
  - On ack: set alloc, clear done, increment tail (wraps modulo ROB_DEPTH), push bank_id into the order FIFO.
  - Bank full: ack stays low and the request must be held. A bank that frees a slot in the same cycle still refuses; the slot is usable next cycle.
- Fill: on d_rc_valid, if the entry has alloc=1 and done=0, write the data and set done. Otherwise the fill is dropped and d_rc_err is set.
- Pop:
  - The order FIFO head names bank b.
  - If done is set at head[b], and the output register is empty or (u_ch_valid & u_ch_ready), then:
    - load the data and b into the output register;
    - clear alloc and done, increment head[b], decrement count[b];
    - pop the order FIFO.
- At most one pop per cycle.
- Same-bank alloc and pop in one cycle: count unchanged.
- Fill and pop to different entries in one cycle: both take effect.
- Output register: u_ch_valid, u_ch_data and u_ch_bank_id are held stable while u_ch_valid & !u_ch_ready.
- Credit: d_crdt_rtn[b] is registered. It is high for exactly one cycle, the cycle after bank b's entry is popped.
- d_rc_err: set by an invalid fill, cleared only by reset.

## Timing
- Reset values (also during async reset):
  - u_ch_valid=0, u_ch_data=0, u_ch_bank_id=0, d_crdt_rtn=0, d_rc_err=0, u_kob_rob_ack=0.
  - All pointers and counts 0; all alloc/done bits 0.
- Reset mid-operation discards every in-flight entry. No credit pulses are issued for discarded entries.
- Alloc: ack and id are combinational in the request cycle. State updates at that clock edge.
- Fill in cycle t: done is visible in t+1. The pop happens at the end of t+1 if the entry is at the order head and the output register is free. u_ch_valid and d_crdt_rtn[b] go high in t+2, giving 2-cycle minimum latency.
- Back-to-back returns at 1 per cycle when the data is ready and u_ch_ready=1.
- Wrap-around: the pointers' MSBs distinguish full from empty. The order FIFO wraps at ORD_DEPTH.

## Configuration
- ROB_MBANK_FILL_BYPASS_EN:
  - Condition: in cycle t, d_rc_valid targets the order-head bank's head entry, that entry has done=0, and the output register is free or draining.
  - Effect: the completion data loads directly into the output register at the end of t. The entry is freed at the same edge, without setting done.
  - u_ch_valid and d_crdt_rtn are high in t+1, giving 1-cycle latency.
- Without the macro, every fill takes the 2-cycle path.

## Test plan
- Ordering across banks: allocate bank0 id0, bank2 id0, bank0 id1, then fill them in reverse order with data 0xA, 0xB, 0xC. u_ch_data returns 0xC, 0xB, 0xA (allocation order), u_ch_bank_id = 0, 2, 0, and d_crdt_rtn[0] pulses twice and d_crdt_rtn[2] once.
- Full bank: perform 8 acks on bank1, then a ninth request gives ack=0. Fill and drain one entry and the ninth request is acked the cycle after the pop, with id=0 (wrap).
- Backpressure: hold u_ch_ready=0 with 3 entries done. u_ch_valid=1 and the data stays stable; no further pops or credits occur. Then ready=1 drains one entry per cycle.
- Error: a fill to an unallocated entry, then a double fill of the same entry. d_rc_err goes to 1 and stays 1; the stored data is unchanged.
- Latency: a single alloc, then a fill at cycle t with ready=1. u_ch_valid rises in t+2 without the macro, and in t+1 with ROB_MBANK_FILL_BYPASS_EN.
- Reset: assert rst_n low with 5 entries outstanding. All outputs go to 0 immediately, and after release the first alloc returns id=0.
